fixed_requant_buffer: RTL and testbench
=======================================

# fixed_requant_buffer

Fixed-point requantization stage that sits directly upstream of the fixed-point activation blocks (hardtanh, relu). It narrows wide accumulator-precision beats from a linear or conv stage to the activation's input precision with round-half-up and saturation. It holds results in a 2-entry elastic buffer so the ready path is registered, and it tags the final beat of each tensor. It also keeps a sticky saturation counter for quantization debugging.

## Interface
- DATA_IN_0_PRECISION_0, 16, input word width (signed)
- DATA_IN_0_PRECISION_1, 8, input fractional bits
- DATA_OUT_0_PRECISION_0, 8, output word width (signed)
- DATA_OUT_0_PRECISION_1, 4, output fractional bits; must be <= DATA_IN_0_PRECISION_1
- DATA_IN_0_TENSOR_SIZE_DIM_0, 8, tensor elements in dim 0
- DATA_IN_0_TENSOR_SIZE_DIM_1, 1, tensor elements in dim 1
- DATA_IN_0_PARALLELISM_DIM_0, 4, lanes per beat in dim 0
- DATA_IN_0_PARALLELISM_DIM_1, 1, lanes per beat in dim 1
- SAT_CNT_WIDTH, 16, saturation counter width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- data_in_0  input  [DATA_IN_0_PRECISION_0-1:0] x P lanes  input beat, P = PAR_DIM_0*PAR_DIM_1
- data_in_0_valid  input  1  input beat valid
- data_in_0_ready  output  1  block accepts input this cycle
- data_out_0  output  [DATA_OUT_0_PRECISION_0-1:0] x P lanes  requantized beat
- data_out_0_valid  output  1  output beat valid
- data_out_0_ready  input  1  downstream accepts
- data_out_0_last  output  1  current output beat is last beat of a tensor
- sat_clear  input  1  synchronous clear of sat_count
- sat_count  output  SAT_CNT_WIDTH  number of accepted beats with at least one saturated lane

## Operation
- Per lane: SHIFT = IN_FRAC - OUT_FRAC. Compute in IN_W+1 bits: t = x + (SHIFT>0 ? 2^(SHIFT-1) : 0); y = t >>> SHIFT (arithmetic); clamp y to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Lane saturated when clamp changed y.
- Rounding is half-up toward +inf: -1.5 -> -1, +1.5 -> +2.
- Accept = data_in_0_valid && data_in_0_ready. Requantized lanes plus a last bit are written into a 2-entry FIFO (head/tail pointers, occupancy count 0..2).
- data_in_0_ready = (count < 2), driven from registered count only, with no combinational path from data_out_0_ready.
- data_out_0_valid = (count > 0). data_out_0 and data_out_0_last come from the head entry. Pop = data_out_0_valid && data_out_0_ready.
- Push and pop in the same cycle: count is unchanged. Push only: count+1. Pop only: count-1.
- Beat counter: BEATS = (TENSOR_DIM_0*TENSOR_DIM_1)/(PAR_DIM_0*PAR_DIM_1).
  - Increments on each accept and wraps to 0 after BEATS-1.
  - The accepted beat with counter == BEATS-1 stores last=1.
  - BEATS == 1 makes every beat last.
- sat_count:
  - Increments by 1 on each accept with any lane saturated.
  - Sticks at all-ones and does not wrap.
  - sat_clear has priority over increment; the next value is 0.
- Values presented while data_in_0_ready=0 are ignored. Output entries stay stable until popped.

## Timing
- Reset (rst low, async): count=0, pointers=0, beat counter=0, sat_count=0. Outputs: data_out_0_valid=0, data_in_0_ready=1 on the first cycle after release, data_out_0_last=0, data_out_0 all 0 (FIFO storage reset to 0).
- Reset mid-transfer discards buffered beats and the partial tensor position. The first beat after release is beat 0.
- Latency: a beat accepted at edge N appears with data_out_0_valid=1 after edge N (1 cycle).
- Throughput: 1 beat/cycle while downstream is ready. With downstream stalled, 2 beats are absorbed, then ready drops the cycle after the second accept.
- Ready rises the cycle after the first pop from a full FIFO.
- sat_count updates the cycle after the accept or clear.

## Test plan
- Lane x=0x0018 (1.5 at output scale), default params -> 0x02. x=0xFFE8 (-1.5) -> 0xFF (-1). x=0x0010 -> 0x01. sat_count stays 0.
- Lane x=0x7FFF -> 0x7F and x=0x8000 -> 0x80 in the same beat -> sat_count increments by 1 (not 2). 0xFFFF consecutive saturating beats followed by one more -> sat_count holds 0xFFFF. Clear asserted concurrently with a saturating accept -> 0.
- Stream 4 tensors back-to-back (BEATS=2) with data_out_0_ready=1 -> one output per cycle, last on beats 1, 3, 5, 7, 1-cycle latency.
- Hold data_out_0_ready=0 and drive 3 valid beats -> first 2 accepted, ready=0 from the cycle after the second accept. Release -> outputs in order, no loss or duplication, ready returns.
- Random valid/ready toggling over 1000 beats against a reference model -> exact data and last match, FIFO never exceeds 2.
- Assert rst mid-tensor with 2 beats buffered -> valid=0 immediately. After release, the next tensor's last falls on its second accepted beat.

Source files
------------

// File: rtl/fixed_requant_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fixed_requant_buffer
// Purpose  : Narrows wide signed fixed-point accumulator beats to activation
//            precision. Each lane uses round-half-up (toward +inf) and then
//            saturates. Results go into a 2-entry elastic buffer, so ready
//            depends only on registered state. The final beat of each tensor
//            is tagged, and a sticky count of saturating beats is kept.
// Ports    : clk              - clock, rising edge
//            rst              - asynchronous reset, active low
//            data_in_0[P]     - input lanes, DATA_IN_0_PRECISION_0 bits signed
//            data_in_0_valid  - input beat valid
//            data_in_0_ready  - buffer has room (count < 2)
//            data_out_0[P]    - requantized lanes from the head entry
//            data_out_0_valid - head entry is valid
//            data_out_0_ready - downstream accepts the head entry
//            data_out_0_last  - head entry is the last beat of a tensor
//            sat_clear        - synchronous clear of sat_count
//            sat_count        - accepted beats with any saturated lane
// Revision : 1.0 - initial release
// ============================================================================
module fixed_requant_buffer #(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int SAT_CNT_WIDTH               = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready,
  output logic                              data_out_0_last,
  input  logic                              sat_clear,
  output logic [SAT_CNT_WIDTH-1:0]          sat_count
);

  localparam int IN_W   = DATA_IN_0_PRECISION_0;
  localparam int OUT_W  = DATA_OUT_0_PRECISION_0;
  localparam int SHIFT  = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
  localparam int P      = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int BEATS  = (DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1) / P;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // One extra bit of headroom so adding the rounding offset cannot overflow.
  localparam logic signed [IN_W:0] C_ROUND    = (IN_W+1)'((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0);
  localparam logic signed [IN_W:0] C_SAT_MAX  = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] C_SAT_MIN  = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [BEAT_W-1:0]    C_LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [OUT_W-1:0]         w_lane_q [P];
  logic [P-1:0]             w_lane_sat;
  logic                     w_accept;
  logic                     w_pop;

  logic [OUT_W-1:0]         mem_q [2][P];
  logic [OUT_W-1:0]         mem_d [2][P];
  logic [1:0]               last_q, last_d;
  logic                     head_q, head_d;
  logic                     tail_q, tail_d;
  logic [1:0]               count_q, count_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  for (genvar i = 0; i < P; i++) begin : g_lane
    logic signed [IN_W:0] w_t;
    logic signed [IN_W:0] w_y;

    assign w_t = $signed({data_in_0[i][IN_W-1], data_in_0[i]}) + C_ROUND;
    // Arithmetic shift floors, so the +half offset above yields round-half-up.
    assign w_y = w_t >>> SHIFT;
    assign w_lane_sat[i] = (w_y > C_SAT_MAX) || (w_y < C_SAT_MIN);
    assign w_lane_q[i]   = (w_y > C_SAT_MAX) ? C_SAT_MAX[OUT_W-1:0] :
                           (w_y < C_SAT_MIN) ? C_SAT_MIN[OUT_W-1:0] :
                                               w_y[OUT_W-1:0];
    assign data_out_0[i] = mem_q[head_q][i];
  end

  // Ready depends only on registered occupancy, so the upstream handshake
  // never sees a combinational path from data_out_0_ready.
  assign data_in_0_ready  = (count_q != 2'd2);
  assign data_out_0_valid = (count_q != 2'd0);
  assign data_out_0_last  = last_q[head_q];
  assign sat_count        = sat_count_q;
  assign w_accept         = data_in_0_valid && data_in_0_ready;
  assign w_pop            = data_out_0_valid && data_out_0_ready;

  always_comb begin
    mem_d       = mem_q;
    last_d      = last_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    beat_d      = beat_q;
    sat_count_d = sat_count_q;

    if (w_accept) begin
      for (int i = 0; i < P; i++) begin
        mem_d[tail_q][i] = w_lane_q[i];
      end
      last_d[tail_q] = (beat_q == C_LAST_BEAT);
      tail_d         = ~tail_q;
      beat_d         = (beat_q == C_LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
    end

    if (w_pop) begin
      head_d = ~head_q;
    end

    case ({w_accept, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Clear wins over increment; the counter sticks at all-ones.
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (w_accept && (|w_lane_sat) && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + SAT_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < 2; e++) begin
        for (int i = 0; i < P; i++) begin
          mem_q[e][i] <= '0;
        end
      end
      last_q      <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= '0;
      beat_q      <= '0;
      sat_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      last_q      <= last_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      sat_count_q <= sat_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_requant_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_requant_buffer
// Purpose  : Directed self-checking bench for fixed_requant_buffer with
//            default parameters (16.8 -> 8.4, 4 lanes, 2 beats per tensor).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_requant_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din [4];
  logic        vin = 1'b0;
  logic        rdy_in;
  logic [7:0]  dout [4];
  logic        vout;
  logic        rdy_out = 1'b0;
  logic        last;
  logic        sat_clear = 1'b0;
  logic [15:0] sat_count;

  int total = 0;
  int bad   = 0;

  fixed_requant_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (din),
    .data_in_0_valid  (vin),
    .data_in_0_ready  (rdy_in),
    .data_out_0       (dout),
    .data_out_0_valid (vout),
    .data_out_0_ready (rdy_out),
    .data_out_0_last  (last),
    .sat_clear        (sat_clear),
    .sat_count        (sat_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 4; i++) din[i] = v;
  endtask

  function automatic logic [31:0] dout_packed();
    return {dout[3], dout[2], dout[1], dout[0]};
  endfunction

  // Reference: round half up by integer division, then clamp to int8.
  function automatic int ref_y(input logic [15:0] x);
    int t;
    int y;
    t = int'($signed(x)) + 8;
    if (t >= 0) y = t / 16;
    else        y = -((-t + 15) / 16);
    return y;
  endfunction

  function automatic logic [7:0] ref_q(input logic [15:0] x);
    int y;
    y = ref_y(x);
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y[7:0];
  endfunction

  function automatic bit ref_sat(input logic [15:0] x);
    int y;
    y = ref_y(x);
    return (y > 127) || (y < -128);
  endfunction

  logic [32:0] mq[$];
  logic [32:0] ent;
  int          mbeat;
  int          msat;
  int          accepted;
  bit          m_acc;
  bit          m_pop;
  bit          anysat;

  initial begin
    set_all(16'h0000);

    // ---------------- reset state ----------------
    #12;
    check("rst_valid", vout, 1'b0);
    check("rst_last", last, 1'b0);
    check("rst_data", dout_packed(), 32'h0);
    check("rst_sat", sat_count, 16'h0);
    rst = 1'b1;
    step();
    check("rst_ready", rdy_in, 1'b1);

    // ---------------- rounding (beat 0 of a tensor) ----------------
    rdy_out = 1'b1;
    din[0] = 16'h0018; din[1] = 16'hFFE8; din[2] = 16'h0010; din[3] = 16'h0000;
    vin = 1'b1;
    step();
    vin = 1'b0;
    check("round_valid", vout, 1'b1);
    check("round_data", dout_packed(), 32'h00_01_FF_02);
    check("round_last", last, 1'b0);
    step();
    check("round_sat", sat_count, 16'h0);
    check("round_drain", vout, 1'b0);

    // ---------------- saturation, both directions in one beat ----------------
    din[0] = 16'h7FFF; din[1] = 16'h8000; din[2] = 16'h0000; din[3] = 16'h0000;
    vin = 1'b1;
    step();
    vin = 1'b0;
    check("sat_data", dout_packed(), 32'h00_00_80_7F);
    check("sat_last", last, 1'b1);
    check("sat_once", sat_count, 16'h1);
    step();

    // ---------------- backpressure ----------------
    rdy_out = 1'b0;
    set_all(16'h0100); vin = 1'b1;
    step();
    check("bp_ready1", rdy_in, 1'b1);
    check("bp_valid1", vout, 1'b1);
    set_all(16'h0200);
    step();
    check("bp_ready2", rdy_in, 1'b0);
    set_all(16'h0300);
    step();
    check("bp_ready3", rdy_in, 1'b0);
    check("bp_hold", dout_packed(), {4{8'h10}});
    vin = 1'b0;
    rdy_out = 1'b1;
    step();
    check("bp_ready_back", rdy_in, 1'b1);
    check("bp_second", dout_packed(), {4{8'h20}});
    check("bp_second_last", last, 1'b1);
    step();
    check("bp_empty", vout, 1'b0);

    // ---------------- streaming 4 tensors ----------------
    for (int k = 0; k < 8; k++) begin
      set_all(16'(k * 16));
      vin = 1'b1;
      step();
      check("strm_valid", vout, 1'b1);
      check("strm_data", dout_packed(), {4{8'(k)}});
      check("strm_last", last, 64'(k % 2));
      check("strm_ready", rdy_in, 1'b1);
    end
    vin = 1'b0;
    step();
    check("strm_empty", vout, 1'b0);

    // ---------------- clear alone ----------------
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    check("clr_alone", sat_count, 16'h0);

    // ---------------- random valid/ready against a model ----------------
    mbeat = 0;
    msat = 0;
    accepted = 0;
    for (int cyc = 0; cyc < 6000 && accepted < 1000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        din[i] = 16'($urandom);
        if ($urandom_range(0, 1) == 1) din[i] = {{6{din[i][15]}}, din[i][15:6]};
      end
      vin     = ($urandom_range(0, 2) != 0);
      rdy_out = ($urandom_range(0, 3) != 0);
      check("rnd_ready", rdy_in, 64'(mq.size() < 2));
      check("rnd_valid", vout, 64'(mq.size() > 0));
      if (mq.size() > 0) check("rnd_data", {last, dout_packed()}, mq[0]);
      m_acc = vin && (mq.size() < 2);
      m_pop = rdy_out && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        anysat = 1'b0;
        for (int i = 0; i < 4; i++) begin
          ent[i*8 +: 8] = ref_q(din[i]);
          if (ref_sat(din[i])) anysat = 1'b1;
        end
        ent[32] = (mbeat == 1);
        mq.push_back(ent);
        mbeat = (mbeat == 1) ? 0 : mbeat + 1;
        if (anysat && msat < 65535) msat++;
        accepted++;
      end
      step();
    end
    check("rnd_budget", 64'(accepted), 64'd1000);
    vin = 1'b0;
    rdy_out = 1'b1;
    for (int cyc = 0; cyc < 4 && mq.size() > 0; cyc++) begin
      check("rnd_drain", {vout, last, dout_packed()}, {1'b1, mq[0]});
      void'(mq.pop_front());
      step();
    end
    check("rnd_empty", vout, 1'b0);
    check("rnd_sat", sat_count, 16'(msat));

    // ---------------- clear priority and sticky saturation ----------------
    set_all(16'h7FFF);
    vin = 1'b1;
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    check("clr_prio", sat_count, 16'h0);
    for (int k = 0; k < 65535; k++) step();
    check("sat_full", sat_count, 16'hFFFF);
    step();
    check("sat_stick", sat_count, 16'hFFFF);
    check("sat_clamp", dout_packed(), {4{8'h7F}});
    vin = 1'b0;
    step();

    // ---------------- reset mid-tensor with 2 buffered ----------------
    set_all(16'h0100);
    vin = 1'b1;
    step();
    vin = 1'b0;
    step();
    rdy_out = 1'b0;
    vin = 1'b1;
    step();
    step();
    vin = 1'b0;
    check("mid_full", rdy_in, 1'b0);
    check("mid_valid", vout, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", vout, 1'b0);
    check("mid_rst_sat", sat_count, 16'h0);
    #3;
    rst = 1'b1;
    step();
    check("mid_rst_ready", rdy_in, 1'b1);
    rdy_out = 1'b1;
    set_all(16'h0040);
    vin = 1'b1;
    step();
    check("post_first", {last, dout_packed()}, {1'b0, {4{8'h04}}});
    step();
    check("post_second", {last, dout_packed()}, {1'b1, {4{8'h04}}});
    vin = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
